wb_mgmt_arbiter: RTL

Two-master Wishbone arbiter that shares the PHY management register slave (5-bit address, 16-bit data, single-cycle classic transfers) between an external requester (MDIO/host bridge, master 0) and an internal requester (link/counter poller, master 1). It grants the bus per Wishbone cycle, with round-robin fairness or a fixed master-0 priority. It routes ack/err/data back to the granted master and optionally terminates stalled transfers with a timeout error. It sits between the requesters and the management slave, in the same clock domain as the PHY core (125 MHz).

---
 rtl/wb_mgmt_arbiter_if.sv | 22 ++
 rtl/wb_mgmt_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/wb_mgmt_arbiter_if.sv
// Wishbone link to the PHY management register slave: 5-bit address, 16-bit data,
// classic single-cycle transfers. Used for both requester ports and the slave port.
interface wb_mgmt_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data_write;
    logic        ack;
    logic        err;
    logic [15:0] data_read;

    modport master (
        output cyc, stb, we, addr, data_write,
        input  ack, err, data_read
    );

    modport slave (
        input  cyc, stb, we, addr, data_write,
        output ack, err, data_read
    );
endinterface

// File: rtl/wb_mgmt_arbiter.sv
// Two-master Wishbone arbiter for the PHY management slave, granted per cycle.
// Optional stall timeout with forced error: define WB_MGMT_ARB_TIMEOUT_EN.
module wb_mgmt_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT        = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_mgmt_arbiter_if.slave   m0,
    wb_mgmt_arbiter_if.slave   m1,
    wb_mgmt_arbiter_if.master  s,
    output logic               busy
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_mgmt_arbiter: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last_grant;
    logic   timeout_hit;
    logic   gnt0, gnt1;
    logic   grant_entry;

    assign gnt0        = (state == GNT0);
    assign gnt1        = (state == GNT1);
    assign grant_entry = (state == IDLE) && (state_next != IDLE);
    assign busy        = (state != IDLE);

    // On a tie, round-robin hands the bus to whichever master did not hold it last.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0.cyc && m1.cyc)
                    state_next = (FIXED_PRIORITY != 0 || last_grant) ? GNT0 : GNT1;
                else if (m0.cyc)
                    state_next = GNT0;
                else if (m1.cyc)
                    state_next = GNT1;
            end
            GNT0:    if (!m0.cyc) state_next = IDLE;
            GNT1:    if (!m1.cyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (grant_entry)
                last_grant <= (state_next == GNT1);
        end
    end

`ifdef WB_MGMT_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign timeout_hit = (state != IDLE) && (to_cnt == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (grant_entry || s.ack || s.err || timeout_hit)
            to_cnt <= '0;
        else if (s.cyc && s.stb)
            to_cnt <= to_cnt + 16'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Idle parks the address/data path on master 0 so the slave sees stable values.
    always_comb begin
        s.cyc        = 1'b0;
        s.stb        = 1'b0;
        s.we         = m0.we;
        s.addr       = m0.addr;
        s.data_write = m0.data_write;
        case (state)
            GNT0: begin
                s.cyc = m0.cyc;
                s.stb = m0.stb && !timeout_hit;
            end
            GNT1: begin
                s.cyc        = m1.cyc;
                s.stb        = m1.stb && !timeout_hit;
                s.we         = m1.we;
                s.addr       = m1.addr;
                s.data_write = m1.data_write;
            end
            default: ;
        endcase
    end

    assign m0.ack       = s.ack && gnt0 && m0.cyc;
    assign m1.ack       = s.ack && gnt1 && m1.cyc;
    assign m0.err       = (s.err || timeout_hit) && gnt0 && m0.cyc;
    assign m1.err       = (s.err || timeout_hit) && gnt1 && m1.cyc;
    assign m0.data_read = s.data_read;
    assign m1.data_read = s.data_read;

endmodule
